// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and constant definitions for alu_pipe
package alu_pkg;

   // Opcode encoding as driven on alu_control
   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_LSL   = 4'b0011,
      ALU_LSR   = 4'b0100,
      ALU_SUB   = 4'b0110,
      ALU_PASSB = 4'b0111,
      ALU_MUL   = 4'b1000
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_BUSY = 2'd1
   } alu_state_t;

   // Fill bit replicated across WIDTH for undefined opcodes
   localparam logic ALU_DEFAULT_RESULT = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int SHAMT_W = $clog2(WIDTH);

   logic               r_busy;
   logic [SHAMT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   w_acc_next;

   // The final step's sum is presented combinationally so the caller can capture it on the done edge
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign done       = r_busy && (r_cnt == SHAMT_W'(WIDTH - 1));
   assign product    = w_acc_next;

   // Latch operands on start, then consume one multiplier bit per cycle; counter stops at WIDTH-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= a;
         r_mplier <= b;
         r_acc    <= '0;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered handshake ALU with NZCV flags; MUL enabled by ALU_PIPE_MUL_EN
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SHAMT_W = $clog2(WIDTH);

   alu_state_t         r_state;
   alu_state_t         w_state_next;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_neg;
   logic               r_carry;
   logic               r_ovf;

   alu_op_t            w_op;
   logic               w_accept;
   logic               w_is_sub;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0]   w_b_op;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_carry;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_load_res;
   logic               w_load;

   logic               w_mul_start;
   logic               w_mul_done;
   logic [WIDTH-1:0]   w_mul_product;

   assign w_op     = alu_op_t'(alu_control);
   assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_shamt  = b[SHAMT_W-1:0];

   // Single WIDTH+1 adder serves ADD and SUB (a + ~b + 1); its MSB is carry / not-borrow
   assign w_is_sub = (w_op == ALU_SUB);
   assign w_b_op   = w_is_sub ? ~b : b;
   assign w_sum    = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};

`ifdef ALU_PIPE_MUL_EN
   assign w_mul_start = w_accept && (w_op == ALU_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (w_mul_start),
      .a       (a),
      .b       (b),
      .done    (w_mul_done),
      .product (w_mul_product)
   );
`else
   assign w_mul_start   = 1'b0;
   assign w_mul_done    = 1'b0;
   assign w_mul_product = '0;
`endif

   // Single-cycle result and arithmetic flags; unknown opcodes fall through to all ones
   always_comb begin
      w_res   = {WIDTH{ALU_DEFAULT_RESULT}};
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (w_op)
         ALU_AND:   w_res = a & b;
         ALU_OR:    w_res = a | b;
         ALU_ADD, ALU_SUB: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_LSL:   w_res = a << w_shamt;
         ALU_LSR:   w_res = a >> w_shamt;
         ALU_PASSB: w_res = b;
         default:   ;
      endcase
   end

   // MUL completion and single-cycle accepts never coincide because in_ready is low while busy
   assign w_load     = (w_accept && !w_mul_start) || w_mul_done;
   assign w_load_res = w_mul_done ? w_mul_product : w_res;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE enters MUL_BUSY only on a MUL accept, returns when the multiplier finishes
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_mul_start) w_state_next = S_MUL_BUSY;
         S_MUL_BUSY: if (w_mul_done)  w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   // One-entry output buffer: loads a new result, otherwise drops valid once consumed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_load_res;
         r_zero      <= (w_load_res == '0);
         r_neg       <= w_load_res[WIDTH-1];
         r_carry     <= w_mul_done ? 1'b0 : w_carry;
         r_ovf       <= w_mul_done ? 1'b0 : w_ovf;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign negative  = r_neg;
   assign carry     = r_carry;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe; follows ALU_PIPE_MUL_EN for MUL expectations
module tb_alu_pipe;

   typedef struct packed {
      logic [63:0] r;
      logic [3:0]  f;
   } sb_entry_t;

`ifdef ALU_PIPE_MUL_EN
   localparam int          MUL_LAT   = 64;
   localparam logic [63:0] MUL_EXP_R = 64'd8369910;
   localparam logic [3:0]  MUL_EXP_F = 4'b0000;
`else
   localparam int          MUL_LAT   = 1;
   localparam logic [63:0] MUL_EXP_R = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [3:0]  MUL_EXP_F = 4'b1000;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [3:0]  alu_control;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int          n_checks = 0;
   int          n_errors = 0;
   sb_entry_t   sb[$];
   sb_entry_t   mon_e;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(64)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .negative    (negative),
      .carry       (carry),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model written from the opcode table, flags as {N,Z,C,V}
   function automatic void model(input logic [3:0] op, input logic [63:0] ia, input logic [63:0] ib,
                                 output logic [63:0] r, output logic [3:0] f);
      logic signed [65:0] t;
      logic [63:0] res;
      logic c;
      logic v;
      c = 1'b0;
      v = 1'b0;
      t = '0;
      case (op)
         4'b0000: res = ia & ib;
         4'b0001: res = ia | ib;
         4'b0010: begin
            res = ia + ib;
            c   = (res < ia);
            t   = $signed({{2{ia[63]}}, ia}) + $signed({{2{ib[63]}}, ib});
            v   = (t[65:63] != 3'b000) && (t[65:63] != 3'b111);
         end
         4'b0110: begin
            res = ia - ib;
            c   = (ia >= ib);
            t   = $signed({{2{ia[63]}}, ia}) - $signed({{2{ib[63]}}, ib});
            v   = (t[65:63] != 3'b000) && (t[65:63] != 3'b111);
         end
         4'b0011: res = ia << ib[5:0];
         4'b0100: res = ia >> ib[5:0];
         4'b0111: res = ib;
`ifdef ALU_PIPE_MUL_EN
         4'b1000: res = ia * ib;
`endif
         default: res = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      r = res;
      f = {res[63], (res == 64'd0), c, v};
   endfunction

   // Present an op and hold it until accepted; expectation is queued at the accepting edge
   task automatic send_op(input logic [3:0] op, input logic [63:0] ia, input logic [63:0] ib,
                          input logic [63:0] er, input logic [3:0] ef, input bit force_rdy,
                          output int waits, output logic ov_seen);
      bit done;
      done    = 1'b0;
      waits   = 0;
      ov_seen = 1'b0;
      in_valid    = 1'b1;
      a           = ia;
      b           = ib;
      alu_control = op;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{r: er, f: ef});
            ov_seen = out_valid;
            done    = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!done) begin
            waits++;
            if (force_rdy) out_ready = 1'b1;
            if (waits > 200) begin
               check("accept_timeout", 64'd1, 64'd0);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic send_model(input logic [3:0] op, input logic [63:0] ia, input logic [63:0] ib);
      logic [63:0] er;
      logic [3:0]  ef;
      int          w;
      logic        ov;
      model(op, ia, ib, er, ef);
      send_op(op, ia, ib, er, ef, 1'b1, w, ov);
   endtask

   // Directed single op with consumer ready: result must appear one cycle after accept
   task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] ia,
                        input logic [63:0] ib, input logic [63:0] er, input logic [3:0] ef);
      int   w;
      logic ov;
      send_op(op, ia, ib, er, ef, 1'b0, w, ov);
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_latency1"}, {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every consumed result is compared against the scoreboard head
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.r);
            check("flags_nzcv", {60'd0, negative, zero, carry, overflow}, {60'd0, mon_e.f});
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   w1, w2, w3, lat, rdy_hi, cnt;
      logic ov1, ov2, ov3;

      reset_n     = 1'b0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      alu_control = '0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_flags", {60'd0, negative, zero, carry, overflow}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Arithmetic, shift and undefined-opcode corner cases
      out_ready = 1'b1;
      do_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001);
      do_op("sub_eq", 4'b0110, 64'd5, 64'd5, 64'd0, 4'b0110);
      do_op("lsl", 4'b0011, 64'd1, 64'h0000_0000_0000_0143, 64'd8, 4'b0000);
      do_op("lsr", 4'b0100, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000);
      do_op("undef", 4'b1111, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
      do_op("sub_borrow", 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);

      // Back-to-back with consumer always ready
      send_op(4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
              64'hF000_F000_F000_F000, 4'b1000, 1'b0, w1, ov1);
      send_op(4'b0001, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
              64'hFFF0_FFF0_FFF0_FFF0, 4'b1000, 1'b0, w2, ov2);
      send_op(4'b0111, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_1234_5678,
              64'h0000_0000_1234_5678, 4'b0000, 1'b0, w3, ov3);
      in_valid = 1'b0;
      check("b2b_waits", w1 + w2 + w3, 64'd0);
      check("b2b_out_valid_2", {63'd0, ov2}, 64'd1);
      check("b2b_out_valid_3", {63'd0, ov3}, 64'd1);
      @(negedge clk);
      check("b2b_last_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;

      // Consumer stall: held result stays put and a new input is refused
      out_ready = 1'b0;
      send_op(4'b0010, 64'd3, 64'd4, 64'd7, 4'b0000, 1'b0, w1, ov1);
      in_valid    = 1'b1;
      a           = 64'hAAAA;
      b           = 64'h5555;
      alu_control = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_result", result, 64'd7);
         check("stall_out_valid", {63'd0, out_valid}, 64'd1);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("stall_no_accept", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;

      // Multiply latency and in_ready while busy
      send_op(4'b1000, 64'd12345, 64'd678, MUL_EXP_R, MUL_EXP_F, 1'b0, w1, ov1);
      in_valid = 1'b0;
      lat      = 0;
      rdy_hi   = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (in_ready) rdy_hi++;
      end
      check("mul_latency", lat, MUL_LAT);
      check("mul_in_ready_busy", rdy_hi, 64'd0);
      @(posedge clk);
      #1;

      // Reset while a result is held
      out_ready = 1'b0;
      send_op(4'b0010, 64'd1, 64'd2, 64'd3, 4'b0000, 1'b0, w1, ov1);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mid_result", result, 64'd0);
      check("rst_mid_flags", {60'd0, negative, zero, carry, overflow}, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Reset during a multiply: nothing may come out afterwards
      out_ready = 1'b1;
      send_op(4'b1000, 64'd12345, 64'd678, MUL_EXP_R, MUL_EXP_F, 1'b0, w1, ov1);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("rst_mul_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("rst_mul_no_output", cnt, 64'd0);
      check("rst_mul_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Random traffic with random consumer back-pressure
      for (int i = 0; i < 60; i++) begin
         logic [3:0]  op;
         logic [63:0] ra;
         logic [63:0] rb;
         op = 4'($urandom_range(0, 15));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = {1'b0, ra[62:0]};
         if ($urandom_range(0, 3) == 0) rb = ra;
         out_ready = ($urandom_range(0, 3) != 0);
         send_model(op, ra, rb);
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while (sb.size() != 0 && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("drain_empty", sb.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
